uart_rx_framed: RTL and testbench

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

---
 rtl/uart_rx_framed.sv | 155 +++++++++++++++
 tb/tb_uart_rx_framed.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with optional parity, 1-2 stop bits and framing/break handling.
// Ports:
//   clock                 in   sole clock, rising edge
//   reset                 in   asynchronous active-high reset
//   signal                in   serial line, idle high, asynchronous to clock
//   can_receive_next_word in   allows a new start bit to be accepted
//   data                  out  last received word, LSB = first data bit
//   ready                 out  one-cycle pulse when data and error flags update
//   parity_error          out  parity mismatch in the last frame
//   framing_error         out  low stop bit in the last frame
//   busy                  out  high whenever the receiver is not idle
module uart_rx_framed #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  signal,
    input  logic                  can_receive_next_word,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  busy
);
    localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF  = TICKS / 2;
    localparam int CW    = $clog2(TICKS) + 1;
    localparam int BW    = $clog2(DATA_WIDTH + 1);
    // The counter fires on the cycle it reads zero, so reloading with N-1
    // places the next sample exactly N clocks after the current one.
    localparam logic [CW-1:0] TICKS_M1 = CW'(TICKS - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);

    if (TICKS < 4 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_framed: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            sync_q, sync_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  parity_error_q, parity_error_d;
    logic                  framing_error_q, framing_error_d;
    logic                  busy_q, busy_d;
    logic                  line, tick;

    assign line = sync_q[1];
    assign tick = cnt_q == '0;

    always_comb begin
        sync_d          = {sync_q[0], signal};
        state_d         = state_q;
        cnt_d           = tick ? cnt_q : cnt_q - 1'b1;
        bits_d          = bits_q;
        shift_d         = shift_q;
        perr_d          = perr_q;
        ferr_d          = ferr_q;
        data_d          = data_q;
        ready_d         = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        case (state_q)
            S_IDLE: if (!line && can_receive_next_word) begin
                state_d = S_START;
                cnt_d   = HALF_M1;
            end
            S_START: if (tick) begin
                state_d = line ? S_IDLE : S_DATA;
                cnt_d   = TICKS_M1;
                bits_d  = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            S_DATA: if (tick) begin
                shift_d = {line, shift_q[DATA_WIDTH-1:1]};
                cnt_d   = TICKS_M1;
                bits_d  = bits_q + 1'b1;
                if (bits_q == BW'(DATA_WIDTH - 1)) begin
                    state_d = PARITY != 0 ? S_PAR : S_STOP;
                    bits_d  = '0;
                end
            end
            S_PAR: if (tick) begin
                // Even: bit must equal XOR of data; odd flips the expectation.
                perr_d  = line ^ (^shift_q) ^ (PARITY == 1);
                state_d = S_STOP;
                cnt_d   = TICKS_M1;
            end
            S_STOP: if (tick) begin
                ferr_d = ferr_q | ~line;
                cnt_d  = TICKS_M1;
                bits_d = bits_q + 1'b1;
                if (bits_q == BW'(STOP_BITS - 1)) begin
                    data_d          = shift_q;
                    ready_d         = 1'b1;
                    parity_error_d  = perr_q;
                    framing_error_d = ferr_q | ~line;
                    // A low line here may be a break; wait for it to rise.
                    state_d         = (ferr_q | ~line) ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: if (line) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bits_q          <= '0;
            shift_q         <= '0;
            sync_q          <= 2'b11;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            data_q          <= '0;
            ready_q         <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bits_q          <= bits_d;
            shift_q         <= shift_d;
            sync_q          <= sync_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
            data_q          <= data_d;
            ready_q         <= ready_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            busy_q          <= busy_d;
        end
    end

    assign data          = data_q;
    assign ready         = ready_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: randomized and directed checks of three receiver configurations against a frame-level model.
module tb_uart_rx_framed;
    localparam int T = 16;
    localparam int H = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sig [3];
    logic       can [3];
    logic       rdy [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       bsy [3];
    logic [7:0] d0, d1;
    logic [6:0] d2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nrdy [3] = '{0, 0, 0};
    int rcyc [3] = '{0, 0, 0};
    int t0   [3] = '{0, 0, 0};
    logic bsy_at_rdy [3];

    // u0: 8N1, u1: 8 data + even parity + 1 stop, u2: 7 data + odd parity + 2 stop
    uart_rx_framed #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clock(clock), .reset(reset), .signal(sig[0]), .can_receive_next_word(can[0]),
        .data(d0), .ready(rdy[0]), .parity_error(pe[0]), .framing_error(fe[0]), .busy(bsy[0]));
    uart_rx_framed #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clock(clock), .reset(reset), .signal(sig[1]), .can_receive_next_word(can[1]),
        .data(d1), .ready(rdy[1]), .parity_error(pe[1]), .framing_error(fe[1]), .busy(bsy[1]));
    uart_rx_framed #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clock(clock), .reset(reset), .signal(sig[2]), .can_receive_next_word(can[2]),
        .data(d2), .ready(rdy[2]), .parity_error(pe[2]), .framing_error(fe[2]), .busy(bsy[2]));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    always @(negedge clock)
        for (int i = 0; i < 3; i++)
            if (rdy[i]) begin
                nrdy[i]++;
                rcyc[i] = cyc;
                bsy_at_rdy[i] = bsy[i];
            end

    function automatic int dw_of(input int u); return u == 2 ? 7 : 8; endfunction
    function automatic int par_of(input int u); return u == 0 ? 0 : (u == 1 ? 2 : 1); endfunction
    function automatic int sb_of(input int u); return u == 2 ? 2 : 1; endfunction
    function automatic logic [8:0] dout(input int u); return u == 0 ? 9'(d0) : (u == 1 ? 9'(d1) : 9'(d2)); endfunction

    // Parity bit a correct transmitter would send for word w on unit u.
    function automatic bit good_par(input int u, input logic [8:0] w);
        logic [8:0] m;
        m = w & 9'((1 << dw_of(u)) - 1);
        return (^m) ^ (par_of(u) == 1);
    endfunction

    // Frame-level expectations: word as transmitted, parity mismatch, any low stop bit.
    function automatic void model(input int u, input logic [8:0] w, input bit pbit, input logic [1:0] stops,
                                  output logic [8:0] ed, output bit ep, output bit ef);
        ed = w & 9'((1 << dw_of(u)) - 1);
        ep = par_of(u) != 0 && pbit != good_par(u, w);
        ef = !stops[0] || (sb_of(u) == 2 && !stops[1]);
    endfunction

    // Ready appears one register cycle after the middle of the last stop bit, seen through the synchroniser.
    function automatic int exp_lat(input int u);
        return H + T * (dw_of(u) + int'(par_of(u) != 0) + sb_of(u)) + 4;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input int u, input logic [8:0] w, input bit pbit, input logic [1:0] stops);
        sig[u] = 1'b0;
        t0[u]  = cyc;
        tick(T);
        for (int i = 0; i < dw_of(u); i++) begin sig[u] = w[i]; tick(T); end
        if (par_of(u) != 0) begin sig[u] = pbit; tick(T); end
        for (int i = 0; i < sb_of(u); i++) begin sig[u] = stops[i]; tick(T); end
        sig[u] = 1'b1;
    endtask

    task automatic test_reset;
        tick(2);
        for (int u = 0; u < 3; u++) begin
            total++; if (dout(u) !== 9'h0 || rdy[u] !== 1'b0 || pe[u] !== 1'b0 || fe[u] !== 1'b0 || bsy[u] !== 1'b0) begin
                bad++; $display("FAIL reset u%0d: data=%0h rdy=%b pe=%b fe=%b busy=%b want all 0", u, dout(u), rdy[u], pe[u], fe[u], bsy[u]);
            end
        end
        reset = 1'b0;
        tick(5);
    endtask

    task automatic test_8n1;
        int n0;
        n0 = nrdy[0];
        send(0, 9'hA5, 1'b0, 2'b11);
        tick(4);
        total++; if (nrdy[0] - n0 !== 1) begin bad++; $display("FAIL 8n1 ready count: got %0d want 1", nrdy[0] - n0); end
        total++; if (d0 !== 8'hA5) begin bad++; $display("FAIL 8n1 data: got %0h want a5", d0); end
        total++; if (pe[0] !== 1'b0 || fe[0] !== 1'b0) begin bad++; $display("FAIL 8n1 errors: got pe=%b fe=%b want 0 0", pe[0], fe[0]); end
        total++; if (bsy_at_rdy[0] !== 1'b0) begin bad++; $display("FAIL 8n1 busy at ready: got %b want 0", bsy_at_rdy[0]); end
        total++; if (rcyc[0] - t0[0] < exp_lat(0) - 1 || rcyc[0] - t0[0] > exp_lat(0) + 1) begin
            bad++; $display("FAIL 8n1 latency: got %0d want %0d", rcyc[0] - t0[0], exp_lat(0));
        end
    endtask

    task automatic test_parity;
        logic [8:0] ed; bit ep, ef;
        for (int k = 0; k < 2; k++) begin
            model(1, 9'h03, k == 0, 2'b11, ed, ep, ef);
            send(1, 9'h03, k == 0, 2'b11);
            tick(4);
            total++; if (d1 !== ed[7:0] || pe[1] !== ep || fe[1] !== ef) begin
                bad++; $display("FAIL parity pbit=%0d: got data=%0h pe=%b fe=%b want %0h %b %b", k == 0, d1, pe[1], fe[1], ed, ep, ef);
            end
        end
    endtask

    task automatic test_framing;
        int n0;
        n0 = nrdy[0];
        send(0, 9'h55, 1'b0, 2'b00);
        sig[0] = 1'b0;
        tick(20 * T);
        total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL break busy mid: got %b want 1", bsy[0]); end
        tick(20 * T);
        total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL break busy end: got %b want 1", bsy[0]); end
        total++; if (nrdy[0] - n0 !== 1 || fe[0] !== 1'b1 || d0 !== 8'h55) begin
            bad++; $display("FAIL break frame: got readies=%0d fe=%b data=%0h want 1 1 55", nrdy[0] - n0, fe[0], d0);
        end
        sig[0] = 1'b1;
        tick(2 * T);
        total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL break release busy: got %b want 0", bsy[0]); end
        send(0, 9'h12, 1'b0, 2'b11);
        tick(4);
        total++; if (d0 !== 8'h12 || fe[0] !== 1'b0 || nrdy[0] - n0 !== 2) begin
            bad++; $display("FAIL after break: got data=%0h fe=%b readies=%0d want 12 0 2", d0, fe[0], nrdy[0] - n0);
        end
    endtask

    task automatic test_glitch;
        int n0, k;
        n0 = nrdy[0];
        sig[0] = 1'b0;
        tick(4);
        sig[0] = 1'b1;
        total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL glitch busy rise: got %b want 1", bsy[0]); end
        k = 0;
        while (bsy[0] && k < H + 4) begin tick(1); k++; end
        total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL glitch busy timeout: busy=%b after %0d cycles", bsy[0], k); end
        tick(3 * T);
        total++; if (nrdy[0] !== n0) begin bad++; $display("FAIL glitch ready: got %0d pulses want 0", nrdy[0] - n0); end
    endtask

    task automatic test_reset_midframe;
        int n0;
        n0 = nrdy[0];
        sig[0] = 1'b0;
        tick(T);
        sig[0] = 1'b1;
        tick(3 * T + H);
        reset = 1'b1;
        #1;
        total++; if (d0 !== 8'h0 || rdy[0] !== 1'b0 || pe[0] !== 1'b0 || fe[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            bad++; $display("FAIL midframe reset: data=%0h rdy=%b pe=%b fe=%b busy=%b want all 0", d0, rdy[0], pe[0], fe[0], bsy[0]);
        end
        tick(3);
        reset = 1'b0;
        tick(2 * T);
        send(0, 9'h3C, 1'b0, 2'b11);
        tick(4);
        total++; if (d0 !== 8'h3C || nrdy[0] - n0 !== 1) begin
            bad++; $display("FAIL after reset: got data=%0h readies=%0d want 3c 1", d0, nrdy[0] - n0);
        end
    endtask

    task automatic test_can_receive;
        int n0;
        n0 = nrdy[0];
        can[0] = 1'b0;
        send(0, 9'h41, 1'b0, 2'b11);
        tick(T);
        total++; if (nrdy[0] !== n0 || bsy[0] !== 1'b0) begin
            bad++; $display("FAIL blocked rx: got readies=%0d busy=%b want 0 0", nrdy[0] - n0, bsy[0]);
        end
        can[0] = 1'b1;
        tick(T);
    endtask

    task automatic test_7o2;
        send(2, 9'h7F, good_par(2, 9'h7F), 2'b01);
        tick(4);
        total++; if (d2 !== 7'h7F || fe[2] !== 1'b1 || pe[2] !== 1'b0) begin
            bad++; $display("FAIL 7o2 second stop: got data=%0h fe=%b pe=%b want 7f 1 0", d2, fe[2], pe[2]);
        end
        send(2, 9'h2A, ~good_par(2, 9'h2A), 2'b11);
        tick(4);
        total++; if (d2 !== 7'h2A || fe[2] !== 1'b0 || pe[2] !== 1'b1) begin
            bad++; $display("FAIL 7o2 odd parity: got data=%0h fe=%b pe=%b want 2a 0 1", d2, fe[2], pe[2]);
        end
    endtask

    task automatic test_random;
        logic [8:0] w, ed; logic [1:0] st; bit pb, ep, ef; int u, n0;
        for (int k = 0; k < 12; k++) begin
            u  = int'($urandom_range(0, 2));
            w  = 9'($urandom);
            pb = good_par(u, w) ^ ($urandom_range(0, 3) == 0);
            st = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11;
            model(u, w, pb, st, ed, ep, ef);
            n0 = nrdy[u];
            send(u, w, pb, st);
            tick(T);
            total++; if (nrdy[u] - n0 !== 1 || dout(u) !== ed || pe[u] !== ep || fe[u] !== ef) begin
                bad++; $display("FAIL random u%0d w=%0h: got readies=%0d data=%0h pe=%b fe=%b want 1 %0h %b %b",
                                u, w, nrdy[u] - n0, dout(u), pe[u], fe[u], ed, ep, ef);
            end
            total++; if (rcyc[u] - t0[u] < exp_lat(u) - 1 || rcyc[u] - t0[u] > exp_lat(u) + 1) begin
                bad++; $display("FAIL random latency u%0d: got %0d want %0d", u, rcyc[u] - t0[u], exp_lat(u));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        int n0;
        n0 = nrdy[1];
        for (int k = 0; k < 3; k++) begin
            w = 8'($urandom);
            send(1, 9'(w), good_par(1, 9'(w)), 2'b11);
            total++; if (d1 !== w || pe[1] !== 1'b0 || fe[1] !== 1'b0) begin
                bad++; $display("FAIL back-to-back %0d: got data=%0h pe=%b fe=%b want %0h 0 0", k, d1, pe[1], fe[1], w);
            end
        end
        tick(4);
        total++; if (nrdy[1] - n0 !== 3) begin bad++; $display("FAIL back-to-back count: got %0d want 3", nrdy[1] - n0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin sig[i] = 1'b1; can[i] = 1'b1; bsy_at_rdy[i] = 1'b1; end
        test_reset;
        test_8n1;
        test_parity;
        test_framing;
        test_glitch;
        test_reset_midframe;
        test_can_receive;
        test_7o2;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
